// File: rtl/arc4_pkg.sv
// arc4_pkg: shared state/phase encodings and defaults for the ARC4 decrypt sequencer
package arc4_pkg;
  typedef enum logic [2:0] {IDLE, WAITR, START, ACK, BUSY, FAULT} seq_state_t;
  typedef enum logic [1:0] {PH_INIT = 2'd0, PH_KSA = 2'd1, PH_PRGA = 2'd2} phase_t;
  localparam int ARC4_TIMEOUT = 16383;
endpackage

// File: rtl/arc4_s_mux.sv
// arc4_s_mux: grant-gated 3:1 mux of sub-block memory address/data/write-enable
module arc4_s_mux import arc4_pkg::*; (
  input  logic [1:0] sel,
  input  logic       valid,
  input  logic [7:0] addr0,
  input  logic [7:0] wrdata0,
  input  logic       wren0,
  input  logic [7:0] addr1,
  input  logic [7:0] wrdata1,
  input  logic       wren1,
  input  logic [7:0] addr2,
  input  logic [7:0] wrdata2,
  input  logic       wren2,
  output logic [7:0] addr,
  output logic [7:0] wrdata,
  output logic       wren
);
  logic hit0, hit1, hit2;
  assign hit0 = valid && sel == PH_INIT;
  assign hit1 = valid && sel == PH_KSA;
  assign hit2 = valid && sel == PH_PRGA;
  always_comb begin
    addr   = hit0 ? addr0   : hit1 ? addr1   : hit2 ? addr2   : 8'h00;
    wrdata = hit0 ? wrdata0 : hit1 ? wrdata1 : hit2 ? wrdata2 : 8'h00;
    wren   = hit0 ? wren0   : hit1 ? wren1   : hit2 ? wren2   : 1'b0;
  end
endmodule

// File: rtl/arc4_seq.sv
// arc4_seq: runs init, ksa, prga in order and grants the S memory port to the active phase
module arc4_seq import arc4_pkg::*; #(
  parameter int TIMEOUT = ARC4_TIMEOUT,
  localparam int CW = $clog2(TIMEOUT + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       rdy,
  output logic       fault,
  output logic [1:0] phase,
  output logic       init_en,
  output logic       ksa_en,
  output logic       prga_en,
  input  logic       init_rdy,
  input  logic       ksa_rdy,
  input  logic       prga_rdy,
  input  logic [7:0] init_addr,
  input  logic [7:0] ksa_addr,
  input  logic [7:0] prga_addr,
  input  logic [7:0] init_wrdata,
  input  logic [7:0] ksa_wrdata,
  input  logic [7:0] prga_wrdata,
  input  logic       init_wren,
  input  logic       ksa_wren,
  input  logic       prga_wren,
  output logic [7:0] s_addr,
  output logic [7:0] s_wrdata,
  output logic       s_wren
);
  seq_state_t    state;
  logic [CW-1:0] wdog;
  logic [2:0]    en_q;
  logic          sel_rdy, grant, bad, tmo;
  assign sel_rdy = phase == PH_INIT ? init_rdy : phase == PH_KSA ? ksa_rdy :
                   phase == PH_PRGA ? prga_rdy : 1'b0;
  assign grant = state inside {WAITR, START, ACK, BUSY};
  assign bad   = phase == 2'd3;
  assign tmo   = wdog == CW'(TIMEOUT - 1);
  assign rdy   = state == IDLE;
  assign fault = state == FAULT;
  assign {prga_en, ksa_en, init_en} = en_q;
  // en_q is loaded on the WAITR->START edge so the pulse covers exactly the START cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      phase <= PH_INIT;
      wdog  <= '0;
      en_q  <= '0;
    end else begin
      en_q <= '0;
      if (grant && bad) state <= FAULT;
      else case (state)
        IDLE: if (en) begin
          state <= WAITR;
          phase <= PH_INIT;
        end
        WAITR: if (sel_rdy) begin
          state <= START;
          en_q  <= 3'b001 << phase;
        end
        START: begin
          state <= ACK;
          wdog  <= '0;
        end
        ACK: begin
          wdog  <= wdog + CW'(1);
          state <= !sel_rdy ? BUSY : tmo ? FAULT : ACK;
        end
        BUSY: begin
          wdog <= wdog + CW'(1);
          if (sel_rdy) begin
            state <= phase == PH_PRGA ? IDLE : WAITR;
            phase <= phase == PH_PRGA ? PH_INIT : phase + 2'd1;
          end else if (tmo) state <= FAULT;
        end
        FAULT: ;
        default: state <= FAULT;
      endcase
    end
  end
  arc4_s_mux u_mux (
    .sel(phase), .valid(grant),
    .addr0(init_addr), .wrdata0(init_wrdata), .wren0(init_wren),
    .addr1(ksa_addr), .wrdata1(ksa_wrdata), .wren1(ksa_wren),
    .addr2(prga_addr), .wrdata2(prga_wrdata), .wren2(prga_wren),
    .addr(s_addr), .wrdata(s_wrdata), .wren(s_wren)
  );
endmodule

// File: tb/tb_arc4_seq.sv
// tb_arc4_seq: stub-driven sequencing, ownership, late-ready, reset and watchdog checks for arc4_seq
module tb_arc4_seq;
  localparam int D0 = 256, D1 = 1792, D2 = 300;
  localparam int LAT = (D0 + 3) + (D1 + 3) + (D2 + 3) + 1;
  logic clk = 1'b0;
  logic rst_n, en, wd_rst_n, wd_en;
  logic [5:0] sen, srdy, hold, rin;
  int sdur[6], scnt[6];
  logic [7:0] addr[3], wdat[3];
  logic [2:0] wren;
  logic m_rdy, m_fault, m_wren, w_rdy, w_fault, w_wren;
  logic [1:0] m_phase, w_phase;
  logic [7:0] m_addr, m_data, w_addr, w_data;
  int checks = 0, failures = 0, cyc = 0, t0;
  int exp_q[$];
  typedef struct {
    logic [7:0] ia, ka, pa, kd;
    logic [2:0] w;
    logic [7:0] ea;
    logic       ew;
    logic [7:0] ed;
  } mux_vec_t;
  mux_vec_t tv[4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign rin = srdy & ~hold;

  arc4_seq dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(m_rdy), .fault(m_fault), .phase(m_phase),
    .init_en(sen[0]), .ksa_en(sen[1]), .prga_en(sen[2]),
    .init_rdy(rin[0]), .ksa_rdy(rin[1]), .prga_rdy(rin[2]),
    .init_addr(addr[0]), .ksa_addr(addr[1]), .prga_addr(addr[2]),
    .init_wrdata(wdat[0]), .ksa_wrdata(wdat[1]), .prga_wrdata(wdat[2]),
    .init_wren(wren[0]), .ksa_wren(wren[1]), .prga_wren(wren[2]),
    .s_addr(m_addr), .s_wrdata(m_data), .s_wren(m_wren)
  );

  arc4_seq #(.TIMEOUT(100)) dut_wd (
    .clk(clk), .rst_n(wd_rst_n), .en(wd_en), .rdy(w_rdy), .fault(w_fault), .phase(w_phase),
    .init_en(sen[3]), .ksa_en(sen[4]), .prga_en(sen[5]),
    .init_rdy(rin[3]), .ksa_rdy(rin[4]), .prga_rdy(rin[5]),
    .init_addr(8'h00), .ksa_addr(8'h00), .prga_addr(8'h33),
    .init_wrdata(8'h00), .ksa_wrdata(8'h00), .prga_wrdata(8'h44),
    .init_wren(1'b0), .ksa_wren(1'b0), .prga_wren(1'b1),
    .s_addr(w_addr), .s_wrdata(w_data), .s_wren(w_wren)
  );

  // sub-block stubs: rdy drops on an accepted en and stays low for sdur cycles (negative = forever)
  always @(posedge clk)
    for (int k = 0; k < 6; k++)
      if (!((k < 3) ? rst_n : wd_rst_n)) begin
        srdy[k] <= 1'b1;
        scnt[k] <= 0;
      end else if (rin[k] && sen[k]) begin
        srdy[k] <= 1'b0;
        scnt[k] <= sdur[k];
      end else if (!srdy[k]) begin
        srdy[k] <= scnt[k] == 1;
        scnt[k] <= scnt[k] - 1;
      end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    int e;
    if (rst_n)
      for (int k = 0; k < 3; k++)
        if (sen[k]) begin
          e = exp_q.size() != 0 ? exp_q.pop_front() : -1;
          chk("en_order", k, e);
        end
  end

  task automatic wait_en(input int k, input int lim);
    int n = 0;
    while (!sen[k] && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("wait_en%0d", k), sen[k], 1);
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (!m_rdy && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle", m_rdy, 1);
  endtask

  task automatic pulse_en();
    en = 1'b1;
    t0 = cyc;
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic check_idle(input string nm);
    chk({nm, "_rdy"}, m_rdy, 1);
    chk({nm, "_fault"}, m_fault, 0);
    chk({nm, "_phase"}, m_phase, 0);
    chk({nm, "_en"}, sen[2:0], 0);
    chk({nm, "_swren"}, m_wren, 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    tv[0] = '{8'hAA, 8'h05, 8'h77, 8'h3C, 3'b011, 8'h05, 1'b1, 8'h3C};
    tv[1] = '{8'hAA, 8'h11, 8'h77, 8'h5A, 3'b100, 8'h11, 1'b0, 8'h5A};
    tv[2] = '{8'h00, 8'hFF, 8'h01, 8'hC3, 3'b111, 8'hFF, 1'b1, 8'hC3};
    tv[3] = '{8'h12, 8'h00, 8'h34, 8'h00, 3'b101, 8'h00, 1'b0, 8'h00};
    sdur = '{D0, D1, D2, 5, 7, -1};
    rst_n = 1'b0; wd_rst_n = 1'b0; en = 1'b0; wd_en = 1'b0; hold = '0;
    addr = '{8'h11, 8'h22, 8'h33}; wdat = '{8'hD0, 8'hD1, 8'hD2}; wren = 3'b111;
    repeat (2) @(negedge clk);
    check_idle("reset");
    chk("reset_saddr", m_addr, 0);
    chk("reset_sdata", m_data, 0);
    rst_n = 1'b1;
    wren = 3'b000;
    @(negedge clk);

    exp_q = '{0, 1, 2};
    pulse_en();
    chk("run1_busy", m_rdy, 0);
    wait_en(1, 400);
    repeat (10) @(negedge clk);
    chk("own_phase", m_phase, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      addr = '{tv[i].ia, tv[i].ka, tv[i].pa};
      wdat[1] = tv[i].kd;
      wren = tv[i].w;
      #1;
      chk($sformatf("own_addr%0d", i), m_addr, tv[i].ea);
      chk($sformatf("own_wren%0d", i), m_wren, tv[i].ew);
      chk($sformatf("own_data%0d", i), m_data, tv[i].ed);
    end
    wait_idle(3000);
    chk("run1_latency", cyc - t0, LAT);
    chk("run1_fault", m_fault, 0);
    chk("run1_sb_empty", exp_q.size(), 0);

    exp_q = '{0, 1, 2};
    pulse_en();
    wait_en(1, 400);
    repeat (100) @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    wait_idle(3000);
    chk("run2_latency", cyc - t0, LAT);
    chk("run2_sb_empty", exp_q.size(), 0);

    begin
      int n = 0;
      logic early = 1'b0;
      hold[1] = 1'b1;
      exp_q = '{0, 1, 2};
      pulse_en();
      while (m_phase != 2'd1 && n < 400) begin
        @(negedge clk);
        n++;
      end
      chk("late_phase", m_phase, 1);
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        early |= sen[1];
      end
      chk("late_no_early_en", early, 0);
      hold[1] = 1'b0;
      chk("late_en_at_release", sen[1], 0);
      @(negedge clk);
      chk("late_en_next", sen[1], 1);
      wait_idle(3000);
      chk("late_fault", m_fault, 0);
      chk("late_sb_empty", exp_q.size(), 0);
    end

    wren = 3'b111;
    exp_q = '{0, 1, 2};
    pulse_en();
    wait_en(1, 400);
    repeat (500) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    exp_q.delete();
    check_idle("midrst");
    rst_n = 1'b1;
    exp_q = '{0, 1, 2};
    pulse_en();
    wait_idle(3000);
    chk("restart_latency", cyc - t0, LAT);
    chk("restart_sb_empty", exp_q.size(), 0);

    wd_rst_n = 1'b1;
    @(negedge clk);
    chk("wd_rdy0", w_rdy, 1);
    wd_en = 1'b1;
    @(negedge clk);
    wd_en = 1'b0;
    wait_en(5, 100);
    repeat (50) @(negedge clk);
    chk("wd_prga_addr", w_addr, 8'h33);
    chk("wd_prga_wren", w_wren, 1);
    repeat (50) @(negedge clk);
    chk("wd_fault_c100", w_fault, 0);
    @(negedge clk);
    chk("wd_fault_c101", w_fault, 1);
    chk("wd_fault_swren", w_wren, 0);
    chk("wd_fault_saddr", w_addr, 0);
    chk("wd_fault_rdy", w_rdy, 0);
    wd_en = 1'b1;
    @(negedge clk);
    wd_en = 1'b0;
    repeat (5) @(negedge clk);
    chk("wd_sticky", w_fault, 1);
    chk("wd_sticky_rdy", w_rdy, 0);
    chk("wd_sticky_en", sen[5:3], 0);
    wd_rst_n = 1'b0;
    @(negedge clk);
    wd_rst_n = 1'b1;
    chk("wd_rst_rdy", w_rdy, 1);
    chk("wd_rst_fault", w_fault, 0);
    chk("wd_rst_phase", w_phase, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
